// File: rtl/ctrl_pkg.sv
// Shared definitions for the LEGv8 control path: opcode patterns, ALU commands
// and the MEM/WB control bundle carried through the EX/MEM register.
package ctrl_pkg;

    localparam logic [9:0]  OP_ADDI_P  = 10'b1001000100;
    localparam logic [10:0] OP_ADDS    = 11'b10101011000;
    localparam logic [10:0] OP_SUBS    = 11'b11101011000;
    localparam logic [10:0] OP_AND     = 11'b10001010000;
    localparam logic [10:0] OP_EOR     = 11'b11001010000;
    localparam logic [10:0] OP_LSL     = 11'b11010011011;
    localparam logic [10:0] OP_LSR     = 11'b11010011010;
    localparam logic [10:0] OP_LDUR    = 11'b11111000010;
    localparam logic [10:0] OP_STUR    = 11'b11111000000;
    localparam logic [10:0] OP_BR      = 11'b11010110000;
    localparam logic [5:0]  OP_B_P     = 6'b000101;
    localparam logic [5:0]  OP_BL_P    = 6'b100101;
    localparam logic [7:0]  OP_BCOND_P = 8'b01010100;
    localparam logic [7:0]  OP_CBZ_P   = 8'b10110100;

    localparam logic [2:0] ALU_PASSB = 3'b000;
    localparam logic [2:0] ALU_ADD   = 3'b010;
    localparam logic [2:0] ALU_SUB   = 3'b011;
    localparam logic [2:0] ALU_AND   = 3'b100;
    localparam logic [2:0] ALU_OR    = 3'b101;
    localparam logic [2:0] ALU_XOR   = 3'b110;

    typedef struct packed {
        logic memToReg;
        logic memWrite;
        logic memRead;
        logic branchLink;
        logic RegWrite;
    } mem_ctrl_t;

    typedef struct packed {
        logic uncondBr;
        logic branch;
        logic Reg2Loc;
        logic ALU_Src;
        logic RegWrite;
        logic ALU_SH;
        logic Imm;
        logic memToReg;
        logic memWrite;
        logic shiftDirn;
        logic ALU_on;
        logic set_flags;
        logic branchReg;
        logic branchLink;
        logic memRead;
    } id_ctrl_t;

endpackage

// File: rtl/ctrl_exmem_unit_if.sv
// EX/MEM bus: EX-stage control/data going in, MEM-stage copies coming out.
interface ctrl_exmem_unit_if #(
    parameter int DATA_W = 64,
    parameter int REG_W  = 5
);
    logic              memToReg_EX, memWrite_EX, memRead_EX, branchLink_EX, RegWrite_EX;
    logic [REG_W-1:0]  targetReg_EX;
    logic [DATA_W-1:0] toDataMem;
    logic [DATA_W-1:0] rd2_EX;
    logic              memToReg_MEM, memWrite_MEM, memRead_MEM, branchLink_MEM, RegWrite_MEM;
    logic [REG_W-1:0]  targetReg_MEM;
    logic [DATA_W-1:0] toDataMem_MEM;
    logic [DATA_W-1:0] rd2_MEM;

    modport master (
        output memToReg_EX, memWrite_EX, memRead_EX, branchLink_EX, RegWrite_EX,
        output targetReg_EX, toDataMem, rd2_EX,
        input  memToReg_MEM, memWrite_MEM, memRead_MEM, branchLink_MEM, RegWrite_MEM,
        input  targetReg_MEM, toDataMem_MEM, rd2_MEM
    );

    modport slave (
        input  memToReg_EX, memWrite_EX, memRead_EX, branchLink_EX, RegWrite_EX,
        input  targetReg_EX, toDataMem, rd2_EX,
        output memToReg_MEM, memWrite_MEM, memRead_MEM, branchLink_MEM, RegWrite_MEM,
        output targetReg_MEM, toDataMem_MEM, rd2_MEM
    );
endinterface

// File: rtl/exmem_pipe_reg.sv
// EX/MEM pipeline register. With EXMEM_FLUSH_EN defined, flush turns the
// captured control bits into a bubble while data still advances.
module exmem_pipe_reg
    import ctrl_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int REG_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
`ifdef EXMEM_FLUSH_EN
    input  logic              flush,
`endif
    input  mem_ctrl_t         ctrl_d,
    input  logic [REG_W-1:0]  target_d,
    input  logic [DATA_W-1:0] result_d,
    input  logic [DATA_W-1:0] store_d,
    output mem_ctrl_t         ctrl_q,
    output logic [REG_W-1:0]  target_q,
    output logic [DATA_W-1:0] result_q,
    output logic [DATA_W-1:0] store_q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_q   <= '0;
            target_q <= '0;
            result_q <= '0;
            store_q  <= '0;
        end else begin
`ifdef EXMEM_FLUSH_EN
            ctrl_q   <= flush ? mem_ctrl_t'('0) : ctrl_d;
`else
            ctrl_q   <= ctrl_d;
`endif
            target_q <= target_d;
            result_q <= result_d;
            store_q  <= store_d;
        end
    end

endmodule

// File: rtl/ctrl_exmem_unit.sv
// LEGv8 control path: ID main decoder, EX ALU-command decoder, EX/MEM register.
// Optional EXMEM_FLUSH_EN adds a flush input that bubbles the EX/MEM control bits.
module ctrl_exmem_unit
    import ctrl_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int REG_W  = 5
) (
    input  logic        clk,
    input  logic        rst,
`ifdef EXMEM_FLUSH_EN
    input  logic        flush,
`endif
    input  logic [10:0] opcode,
    output logic        uncondBr, branch, Reg2Loc, ALU_Src, RegWrite,
    output logic        ALU_SH, Imm, memToReg, memWrite, shiftDirn,
    output logic        ALU_on, set_flags, branchReg, branchLink, memRead,
    input  logic [10:0] opcode_EX,
    input  logic        ALU_on_EX,
    input  logic        sign,
    output logic [2:0]  ALU_cntrl,
    ctrl_exmem_unit_if.slave ex_mem
);

    id_ctrl_t id_c;

    always_comb begin
        id_c = '0;
        if (!rst) begin
            if (opcode[10:1] == OP_ADDI_P) begin
                id_c.RegWrite = 1'b1; id_c.ALU_Src = 1'b1; id_c.Imm = 1'b1; id_c.ALU_on = 1'b1;
            end else if (opcode == OP_ADDS || opcode == OP_SUBS) begin
                id_c.RegWrite = 1'b1; id_c.Reg2Loc = 1'b1; id_c.ALU_on = 1'b1; id_c.set_flags = 1'b1;
            end else if (opcode == OP_AND || opcode == OP_EOR) begin
                id_c.RegWrite = 1'b1; id_c.Reg2Loc = 1'b1; id_c.ALU_on = 1'b1;
            end else if (opcode == OP_LSL || opcode == OP_LSR) begin
                id_c.RegWrite = 1'b1; id_c.ALU_SH = 1'b1; id_c.shiftDirn = opcode[0] ? 1'b0 : 1'b1;
            end else if (opcode == OP_LDUR) begin
                id_c.RegWrite = 1'b1; id_c.ALU_Src = 1'b1; id_c.memToReg = 1'b1;
                id_c.memRead = 1'b1; id_c.ALU_on = 1'b1;
            end else if (opcode == OP_STUR) begin
                id_c.ALU_Src = 1'b1; id_c.memWrite = 1'b1; id_c.ALU_on = 1'b1;
            end else if (opcode[10:5] == OP_B_P) begin
                id_c.branch = 1'b1; id_c.uncondBr = 1'b1;
            end else if (opcode[10:5] == OP_BL_P) begin
                id_c.branch = 1'b1; id_c.uncondBr = 1'b1; id_c.branchLink = 1'b1;
                id_c.RegWrite = 1'b1; id_c.ALU_on = 1'b1;
            end else if (opcode[10:3] == OP_BCOND_P) begin
                id_c.branch = 1'b1;
            end else if (opcode[10:3] == OP_CBZ_P) begin
                id_c.branch = 1'b1; id_c.ALU_on = 1'b1;
            end else if (opcode == OP_BR) begin
                id_c.branchReg = 1'b1;
            end
        end
    end

    assign {uncondBr, branch, Reg2Loc, ALU_Src, RegWrite, ALU_SH, Imm, memToReg,
            memWrite, shiftDirn, ALU_on, set_flags, branchReg, branchLink, memRead} = id_c;

    // Memory offsets arrive as a magnitude, so a negative offset means subtract.
    always_comb begin
        ALU_cntrl = ALU_PASSB;
        if (ALU_on_EX) begin
            if (opcode_EX[10:1] == OP_ADDI_P || opcode_EX == OP_ADDS || opcode_EX[10:5] == OP_BL_P)
                ALU_cntrl = ALU_ADD;
            else if (opcode_EX == OP_SUBS)
                ALU_cntrl = ALU_SUB;
            else if (opcode_EX == OP_AND)
                ALU_cntrl = ALU_AND;
            else if (opcode_EX == OP_EOR)
                ALU_cntrl = ALU_XOR;
            else if (opcode_EX == OP_LDUR || opcode_EX == OP_STUR)
                ALU_cntrl = sign ? ALU_SUB : ALU_ADD;
        end
    end

    mem_ctrl_t ctrl_ex, ctrl_mem;

    assign ctrl_ex = '{memToReg:   ex_mem.memToReg_EX,
                       memWrite:   ex_mem.memWrite_EX,
                       memRead:    ex_mem.memRead_EX,
                       branchLink: ex_mem.branchLink_EX,
                       RegWrite:   ex_mem.RegWrite_EX};

    exmem_pipe_reg #(.DATA_W(DATA_W), .REG_W(REG_W)) u_exmem (
        .clk      (clk),
        .rst      (rst),
`ifdef EXMEM_FLUSH_EN
        .flush    (flush),
`endif
        .ctrl_d   (ctrl_ex),
        .target_d (ex_mem.targetReg_EX),
        .result_d (ex_mem.toDataMem),
        .store_d  (ex_mem.rd2_EX),
        .ctrl_q   (ctrl_mem),
        .target_q (ex_mem.targetReg_MEM),
        .result_q (ex_mem.toDataMem_MEM),
        .store_q  (ex_mem.rd2_MEM)
    );

    assign ex_mem.memToReg_MEM   = ctrl_mem.memToReg;
    assign ex_mem.memWrite_MEM   = ctrl_mem.memWrite;
    assign ex_mem.memRead_MEM    = ctrl_mem.memRead;
    assign ex_mem.branchLink_MEM = ctrl_mem.branchLink;
    assign ex_mem.RegWrite_MEM   = ctrl_mem.RegWrite;

endmodule

// File: tb/tb_ctrl_exmem_unit.sv
// Self-checking bench for ctrl_exmem_unit: table-driven decoder reference and
// a one-deep capture model of the EX/MEM register, with directed and random steps.
module tb_ctrl_exmem_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [10:0] opcode, opcode_EX;
    logic        ALU_on_EX, sign;
    logic        uncondBr, branch, Reg2Loc, ALU_Src, RegWrite, ALU_SH, Imm, memToReg;
    logic        memWrite, shiftDirn, ALU_on, set_flags, branchReg, branchLink, memRead;
    logic [2:0]  ALU_cntrl;
`ifdef EXMEM_FLUSH_EN
    logic        flush = 1'b0;
`endif

    ctrl_exmem_unit_if #(.DATA_W(64), .REG_W(5)) bus ();

    ctrl_exmem_unit #(.DATA_W(64), .REG_W(5)) dut (
        .clk(clk), .rst(rst),
`ifdef EXMEM_FLUSH_EN
        .flush(flush),
`endif
        .opcode(opcode),
        .uncondBr(uncondBr), .branch(branch), .Reg2Loc(Reg2Loc), .ALU_Src(ALU_Src),
        .RegWrite(RegWrite), .ALU_SH(ALU_SH), .Imm(Imm), .memToReg(memToReg),
        .memWrite(memWrite), .shiftDirn(shiftDirn), .ALU_on(ALU_on), .set_flags(set_flags),
        .branchReg(branchReg), .branchLink(branchLink), .memRead(memRead),
        .opcode_EX(opcode_EX), .ALU_on_EX(ALU_on_EX), .sign(sign), .ALU_cntrl(ALU_cntrl),
        .ex_mem(bus)
    );

    always #5 clk = ~clk;

    // Bit positions of the ID control vector {uncondBr ... memRead}.
    localparam int UNC = 14, BRN = 13, R2L = 12, ASRC = 11, RW = 10, ASH = 9, IMM = 8;
    localparam int M2R = 7, MW = 6, SHD = 5, AON = 4, SF = 3, BRR = 2, BLK = 1, MR = 0;

    typedef enum int {I_NOP, I_ADDI, I_ADDS, I_SUBS, I_AND, I_EOR, I_LSL, I_LSR,
                      I_LDUR, I_STUR, I_B, I_BL, I_BCOND, I_CBZ, I_BR} instr_e;

    logic [10:0] t_mask [15];
    logic [10:0] t_pat  [15];
    logic [14:0] t_bits [15];

    int passed = 0, total = 0;

    function automatic logic [14:0] b(int k);
        return 15'(1) << k;
    endfunction

    function automatic int classify(logic [10:0] op);
        for (int i = 1; i < 15; i++)
            if ((op & t_mask[i]) == t_pat[i]) return i;
        return I_NOP;
    endfunction

    function automatic logic [2:0] ref_alu(logic [10:0] op, logic on, logic sg);
        if (!on) return 3'b000;
        case (classify(op))
            I_ADDI, I_ADDS, I_BL: return 3'b010;
            I_SUBS:               return 3'b011;
            I_AND:                return 3'b100;
            I_EOR:                return 3'b110;
            I_LDUR, I_STUR:       return sg ? 3'b011 : 3'b010;
            default:              return 3'b000;
        endcase
    endfunction

    task automatic add_entry(int idx, logic [10:0] m, logic [10:0] p, logic [14:0] bits);
        t_mask[idx] = m; t_pat[idx] = p; t_bits[idx] = bits;
    endtask

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    function automatic logic [14:0] id_obs();
        return {uncondBr, branch, Reg2Loc, ALU_Src, RegWrite, ALU_SH, Imm, memToReg,
                memWrite, shiftDirn, ALU_on, set_flags, branchReg, branchLink, memRead};
    endfunction

    function automatic logic [4:0] mem_ctrl_obs();
        return {bus.memToReg_MEM, bus.memWrite_MEM, bus.memRead_MEM,
                bus.branchLink_MEM, bus.RegWrite_MEM};
    endfunction

    task automatic drive_ex(logic [4:0] c, logic [4:0] tr, logic [63:0] res, logic [63:0] st);
        {bus.memToReg_EX, bus.memWrite_EX, bus.memRead_EX, bus.branchLink_EX, bus.RegWrite_EX} = c;
        bus.targetReg_EX = tr; bus.toDataMem = res; bus.rd2_EX = st;
    endtask

    task automatic check_id(string tag, logic [10:0] op);
        opcode = op;
        #1;
        chk(tag, 64'(id_obs()), 64'(t_bits[classify(op)]));
    endtask

    task automatic check_alu(string tag, logic [10:0] op, logic on, logic sg);
        opcode_EX = op; ALU_on_EX = on; sign = sg;
        #1;
        chk(tag, 64'(ALU_cntrl), 64'(ref_alu(op, on, sg)));
    endtask

    task automatic check_mem(string tag, logic [4:0] c, logic [4:0] tr, logic [63:0] res, logic [63:0] st);
        chk({tag, "_ctrl"}, 64'(mem_ctrl_obs()), 64'(c));
        chk({tag, "_tr"},   64'(bus.targetReg_MEM), 64'(tr));
        chk({tag, "_res"},  bus.toDataMem_MEM, res);
        chk({tag, "_st"},   bus.rd2_MEM, st);
    endtask

    logic [4:0]  e_c, n_c;
    logic [4:0]  e_tr, n_tr;
    logic [63:0] e_res, e_st, n_res, n_st;

    function automatic logic [10:0] rand_opcode();
        int k = $urandom_range(0, 14);
        logic [10:0] r = 11'($urandom);
        if (k == 0) return r;
        return t_pat[k] | (r & ~t_mask[k]);
    endfunction

    initial begin
        add_entry(I_NOP,   11'h000,         11'h000,         15'h0);
        add_entry(I_ADDI,  11'b11111111110, 11'b10010001000, b(RW)|b(ASRC)|b(IMM)|b(AON));
        add_entry(I_ADDS,  11'h7FF,         11'b10101011000, b(RW)|b(R2L)|b(AON)|b(SF));
        add_entry(I_SUBS,  11'h7FF,         11'b11101011000, b(RW)|b(R2L)|b(AON)|b(SF));
        add_entry(I_AND,   11'h7FF,         11'b10001010000, b(RW)|b(R2L)|b(AON));
        add_entry(I_EOR,   11'h7FF,         11'b11001010000, b(RW)|b(R2L)|b(AON));
        add_entry(I_LSL,   11'h7FF,         11'b11010011011, b(RW)|b(ASH));
        add_entry(I_LSR,   11'h7FF,         11'b11010011010, b(RW)|b(ASH)|b(SHD));
        add_entry(I_LDUR,  11'h7FF,         11'b11111000010, b(RW)|b(ASRC)|b(M2R)|b(MR)|b(AON));
        add_entry(I_STUR,  11'h7FF,         11'b11111000000, b(ASRC)|b(MW)|b(AON));
        add_entry(I_B,     11'b11111100000, 11'b00010100000, b(BRN)|b(UNC));
        add_entry(I_BL,    11'b11111100000, 11'b10010100000, b(BRN)|b(UNC)|b(BLK)|b(RW)|b(AON));
        add_entry(I_BCOND, 11'b11111111000, 11'b01010100000, b(BRN));
        add_entry(I_CBZ,   11'b11111111000, 11'b10110100000, b(BRN)|b(AON));
        add_entry(I_BR,    11'h7FF,         11'b11010110000, b(BRR));

        // Reset asserted from time zero, before any clock edge.
        rst = 1'b1;
        opcode = 11'b10101011000; opcode_EX = 11'b10101011000; ALU_on_EX = 1'b1; sign = 1'b1;
        drive_ex(5'h1F, 5'h1F, '1, '1);
        #1;
        chk("rst_id", 64'(id_obs()), 64'h0);
        check_mem("rst_mem", 5'h0, 5'h0, 64'h0, 64'h0);

        @(posedge clk); #1;
        check_mem("rst_hold", 5'h0, 5'h0, 64'h0, 64'h0);
        rst = 1'b0;

        check_id("ldur", 11'b11111000010);
        chk("ldur_exact", 64'(id_obs()), 64'(b(RW)|b(ASRC)|b(M2R)|b(MR)|b(AON)));
        check_alu("alu_ldur_neg", 11'b11111000010, 1'b1, 1'b1);
        chk("alu_ldur_neg_exact", 64'(ALU_cntrl), 64'(3'b011));
        check_alu("alu_ldur_pos", 11'b11111000010, 1'b1, 1'b0);
        chk("alu_ldur_pos_exact", 64'(ALU_cntrl), 64'(3'b010));
        check_id("bl", 11'b10010110101);
        check_id("bcond", 11'b01010100110);
        check_id("br", 11'b11010110000);
        check_id("undef", 11'b00000000000);
        check_id("lsr", 11'b11010011010);
        check_alu("alu_subs", 11'b11101011000, 1'b1, 1'b0);
        check_alu("alu_eor", 11'b11001010000, 1'b1, 1'b0);
        check_alu("alu_and", 11'b10001010000, 1'b1, 1'b1);
        check_alu("alu_off", 11'b10101011000, 1'b0, 1'b0);
        check_alu("alu_cbz", 11'b10110100011, 1'b1, 1'b0);

        // Directed capture, then inputs change between edges and outputs must hold.
        drive_ex(5'b00001, 5'd9, 64'h0000_0000_0000_0028, 64'h0000_0000_DEAD_BEEF);
        @(posedge clk); #1;
        check_mem("cap", 5'b00001, 5'd9, 64'h28, 64'hDEAD_BEEF);
        drive_ex(5'b11110, 5'd3, 64'h1234, 64'h5678);
        #3;
        check_mem("hold", 5'b00001, 5'd9, 64'h28, 64'hDEAD_BEEF);
        @(posedge clk); #1;
        check_mem("cap2", 5'b11110, 5'd3, 64'h1234, 64'h5678);
        e_c = 5'b11110; e_tr = 5'd3; e_res = 64'h1234; e_st = 64'h5678;

`ifdef EXMEM_FLUSH_EN
        drive_ex(5'b01000, 5'd4, 64'h10, 64'h99);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_mw", 64'(bus.memWrite_MEM), 64'h0);
        chk("flush_res", bus.toDataMem_MEM, 64'h10);
        e_c = 5'b0; e_tr = 5'd4; e_res = 64'h10; e_st = 64'h99;
`endif

        for (int i = 0; i < 150; i++) begin
            n_c = 5'($urandom); n_tr = 5'($urandom);
            n_res = {$urandom, $urandom}; n_st = {$urandom, $urandom};
            drive_ex(n_c, n_tr, n_res, n_st);
`ifdef EXMEM_FLUSH_EN
            flush = ($urandom_range(0, 3) == 0);
            if (flush) n_c = 5'b0;
`endif
            check_id("rnd_id", rand_opcode());
            check_alu("rnd_alu", rand_opcode(), 1'($urandom), 1'($urandom));
            check_mem("rnd_pre", e_c, e_tr, e_res, e_st);
            @(posedge clk); #1;
            e_c = n_c; e_tr = n_tr; e_res = n_res; e_st = n_st;
            check_mem("rnd", e_c, e_tr, e_res, e_st);

            // Mid-cycle asynchronous reset, then resumption on the next edge.
            if (i == 75) begin
                opcode = 11'b10101011000;
                #2 rst = 1'b1;
                #1;
                chk("arst_id", 64'(id_obs()), 64'h0);
                check_mem("arst", 5'h0, 5'h0, 64'h0, 64'h0);
                @(posedge clk); #1;
                check_mem("arst_hold", 5'h0, 5'h0, 64'h0, 64'h0);
                rst = 1'b0;
                e_c = 5'h0; e_tr = 5'h0; e_res = 64'h0; e_st = 64'h0;
            end
        end
`ifdef EXMEM_FLUSH_EN
        flush = 1'b0;
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
